// File: rtl/hdmi_pll_rst_seq.sv
// rtl/hdmi_pll_rst_seq.sv - HDMI PLL reset/lock sequencer
//
// Purpose:
//   Pulses the PLL reset, waits for lock with a timeout, requires lock to
//   stay continuously asserted before releasing the downstream HDMI logic,
//   re-sequences on lock loss and latches a failure after repeated timeouts.
//   Everything runs on the free-running reference clock.
//
// Ports:
//   refclk      in   reference clock (only clock)
//   rst         in   synchronous active-high reset
//   pll_locked  in   PLL lock indication, asynchronous to refclk
//   pll_rst     out  reset to the PLL, active-high
//   sys_rst     out  reset to downstream HDMI logic, active-high
//   ready       out  PLL locked and stable, system running
//   lock_loss   out  one-cycle pulse when lock drops while running
//   lock_fail   out  sticky, retry limit reached
//   retry_cnt   out  timeouts since rst, saturating at 255

module hdmi_pll_rst_seq #(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 40000,
    parameter int LOCK_STABLE    = 4096,
    parameter int RETRY_MAX      = 3
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic       lock_loss,
    output logic       lock_fail,
    output logic [7:0] retry_cnt
);

    localparam int MAX_AB  = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_CYC = (MAX_AB > LOCK_STABLE) ? MAX_AB : LOCK_STABLE;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;

    localparam logic [2:0] S_PLL_RESET = 3'd0;
    localparam logic [2:0] S_WAIT_LOCK = 3'd1;
    localparam logic [2:0] S_STABLE    = 3'd2;
    localparam logic [2:0] S_RUN       = 3'd3;
    localparam logic [2:0] S_FAIL      = 3'd4;

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       retry_q, retry_d;
    logic             pll_rst_q, pll_rst_d;
    logic             sys_rst_q, sys_rst_d;
    logic             ready_q, ready_d;
    logic             lock_loss_q, lock_loss_d;
    logic             lock_fail_q, lock_fail_d;

    logic             locked_s;
    logic [7:0]       retry_inc;

    assign locked_s  = sync2_q;
    assign retry_inc = (retry_q == 8'hFF) ? retry_q : retry_q + 8'd1;

    always_comb begin
        sync1_d     = pll_locked;
        sync2_d     = sync1_q;
        state_d     = state_q;
        cnt_d       = cnt_q + 1'b1;
        retry_d     = retry_q;
        lock_loss_d = 1'b0;

        case (state_q)
            S_PLL_RESET: begin
                if (cnt_q == CNT_W'(PLL_RST_CYCLES - 1)) begin
                    state_d = S_WAIT_LOCK;
                end
            end
            S_WAIT_LOCK: begin
                // Lock takes priority over a coincident timeout.
                if (locked_s) begin
                    state_d = S_STABLE;
                end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
                    retry_d = retry_inc;
                    if ((RETRY_MAX != 0) && (int'({24'd0, retry_inc}) >= RETRY_MAX)) begin
                        state_d = S_FAIL;
                    end else begin
                        state_d = S_PLL_RESET;
                    end
                end
            end
            S_STABLE: begin
                if (!locked_s) begin
                    state_d = S_WAIT_LOCK;
                end else if (cnt_q == CNT_W'(LOCK_STABLE - 1)) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                cnt_d = cnt_q;
                if (!locked_s) begin
                    state_d     = S_PLL_RESET;
                    lock_loss_d = 1'b1;
                end
            end
            S_FAIL: begin
                cnt_d = cnt_q;
            end
            default: begin
                state_d = S_PLL_RESET;
            end
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end

        // Outputs decode the next state so they move on the same edge as it.
        pll_rst_d   = (state_d == S_PLL_RESET) || (state_d == S_FAIL);
        sys_rst_d   = (state_d != S_RUN);
        ready_d     = (state_d == S_RUN);
        lock_fail_d = (state_d == S_FAIL);
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            state_q     <= S_PLL_RESET;
            cnt_q       <= '0;
            retry_q     <= 8'd0;
            pll_rst_q   <= 1'b1;
            sys_rst_q   <= 1'b1;
            ready_q     <= 1'b0;
            lock_loss_q <= 1'b0;
            lock_fail_q <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            pll_rst_q   <= pll_rst_d;
            sys_rst_q   <= sys_rst_d;
            ready_q     <= ready_d;
            lock_loss_q <= lock_loss_d;
            lock_fail_q <= lock_fail_d;
        end
    end

    assign pll_rst   = pll_rst_q;
    assign sys_rst   = sys_rst_q;
    assign ready     = ready_q;
    assign lock_loss = lock_loss_q;
    assign lock_fail = lock_fail_q;
    assign retry_cnt = retry_q;

endmodule

// File: tb/tb_hdmi_pll_rst_seq.sv
// tb/tb_hdmi_pll_rst_seq.sv - self-checking bench for hdmi_pll_rst_seq
module tb_hdmi_pll_rst_seq;

    localparam int PRC = 4;
    localparam int LTO = 20;
    localparam int LST = 8;
    localparam int RMX = 3;

    localparam int P_RST  = 0;
    localparam int P_WAIT = 1;
    localparam int P_STB  = 2;
    localparam int P_RUN  = 3;
    localparam int P_FAIL = 4;

    typedef struct {
        int phase;
        int t;
        int retries;
        bit lost;
        bit h0;
        bit h1;
    } model_t;

    logic       refclk = 1'b0;
    logic       rst_a, lk_a, rst_b, lk_b;
    logic       pll_rst_a, sys_rst_a, ready_a, lock_loss_a, lock_fail_a;
    logic       pll_rst_b, sys_rst_b, ready_b, lock_loss_b, lock_fail_b;
    logic [7:0] retry_a, retry_b;

    int     n_chk = 0;
    int     n_fail = 0;
    int     stepn = 0;
    int     b_rises = 0;
    bit     b_prev = 1'b0;
    model_t ma, mb;

    always #5 refclk = ~refclk;

    hdmi_pll_rst_seq #(
        .PLL_RST_CYCLES(PRC), .LOCK_TIMEOUT(LTO), .LOCK_STABLE(LST), .RETRY_MAX(RMX)
    ) dut_a (
        .refclk(refclk), .rst(rst_a), .pll_locked(lk_a),
        .pll_rst(pll_rst_a), .sys_rst(sys_rst_a), .ready(ready_a),
        .lock_loss(lock_loss_a), .lock_fail(lock_fail_a), .retry_cnt(retry_a)
    );

    hdmi_pll_rst_seq #(
        .PLL_RST_CYCLES(PRC), .LOCK_TIMEOUT(LTO), .LOCK_STABLE(LST), .RETRY_MAX(0)
    ) dut_b (
        .refclk(refclk), .rst(rst_b), .pll_locked(lk_b),
        .pll_rst(pll_rst_b), .sys_rst(sys_rst_b), .ready(ready_b),
        .lock_loss(lock_loss_b), .lock_fail(lock_fail_b), .retry_cnt(retry_b)
    );

    // Advance the behavioural model by one refclk edge given the inputs at that edge.
    // h1 is the PLL lock level seen two edges ago, i.e. what the sequencer acts on.
    function automatic model_t mstep(input model_t m, input bit r, input bit lk, input int rmax);
        model_t n;
        n = m;
        n.lost = 1'b0;
        if (r) begin
            n.phase = P_RST; n.t = 0; n.retries = 0; n.h0 = 1'b0; n.h1 = 1'b0;
            return n;
        end
        case (m.phase)
            P_RST: begin
                n.t = m.t + 1;
                if (n.t == PRC) begin n.phase = P_WAIT; n.t = 0; end
            end
            P_WAIT: begin
                if (m.h1) begin
                    n.phase = P_STB; n.t = 0;
                end else begin
                    n.t = m.t + 1;
                    if (n.t == LTO) begin
                        n.t = 0;
                        n.retries = (m.retries < 255) ? m.retries + 1 : 255;
                        n.phase = (rmax != 0 && n.retries >= rmax) ? P_FAIL : P_RST;
                    end
                end
            end
            P_STB: begin
                if (!m.h1) begin
                    n.phase = P_WAIT; n.t = 0;
                end else begin
                    n.t = m.t + 1;
                    if (n.t == LST) begin n.phase = P_RUN; n.t = 0; end
                end
            end
            P_RUN: begin
                if (!m.h1) begin n.phase = P_RST; n.t = 0; n.lost = 1'b1; end
            end
            default: ;
        endcase
        n.h1 = m.h0;
        n.h0 = lk;
        return n;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at step %0d: got %0d expected %0d", name, stepn, act, exp);
        end
    endtask

    task automatic cmp_all();
        chk("a_pll_rst",   int'(pll_rst_a),   int'(ma.phase == P_RST || ma.phase == P_FAIL));
        chk("a_sys_rst",   int'(sys_rst_a),   int'(ma.phase != P_RUN));
        chk("a_ready",     int'(ready_a),     int'(ma.phase == P_RUN));
        chk("a_lock_loss", int'(lock_loss_a), int'(ma.lost));
        chk("a_lock_fail", int'(lock_fail_a), int'(ma.phase == P_FAIL));
        chk("a_retry_cnt", int'(retry_a),     ma.retries);
        chk("b_pll_rst",   int'(pll_rst_b),   int'(mb.phase == P_RST || mb.phase == P_FAIL));
        chk("b_sys_rst",   int'(sys_rst_b),   int'(mb.phase != P_RUN));
        chk("b_ready",     int'(ready_b),     int'(mb.phase == P_RUN));
        chk("b_lock_loss", int'(lock_loss_b), int'(mb.lost));
        chk("b_lock_fail", int'(lock_fail_b), int'(mb.phase == P_FAIL));
        chk("b_retry_cnt", int'(retry_b),     mb.retries);
    endtask

    // One refclk cycle: drive inputs, take the edge, advance both models, compare.
    task automatic step(input bit ra, input bit la);
        bit rb;
        rb = (stepn < 2);
        rst_a = ra; lk_a = la; rst_b = rb; lk_b = 1'b0;
        @(posedge refclk);
        #1;
        ma = mstep(ma, ra, la, RMX);
        mb = mstep(mb, rb, 1'b0, 0);
        stepn++;
        cmp_all();
        if (stepn >= 7200 && pll_rst_b && !b_prev) b_rises++;
        b_prev = pll_rst_b;
    endtask

    task automatic wait_ready(output int n, input bit lk, input int limit);
        n = 0;
        while (!ready_a && n < limit) begin
            step(1'b0, lk);
            n++;
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pll_rst"},   int'(pll_rst_a),   1);
        chk({tag, "_sys_rst"},   int'(sys_rst_a),   1);
        chk({tag, "_ready"},     int'(ready_a),     0);
        chk({tag, "_lock_fail"}, int'(lock_fail_a), 0);
        chk({tag, "_retry"},     int'(retry_a),     0);
    endtask

    initial begin
        int n;
        int lvl;
        int len;

        // Reset state
        repeat (3) step(1'b1, 1'b0);
        chk_reset_vals("reset");

        // Nominal lock: pll_locked raised on cycle 10
        for (int k = 1; k <= 9; k++) begin
            step(1'b0, 1'b0);
            if (k == 3) chk("nom_pll_rst_c3", int'(pll_rst_a), 1);
            if (k == 4) chk("nom_pll_rst_c4", int'(pll_rst_a), 0);
        end
        step(1'b0, 1'b1);
        wait_ready(n, 1'b1, 50);
        chk("nominal_latency", n, 10);
        chk("nominal_retry", int'(retry_a), 0);

        // Lock loss in RUN
        repeat (5) step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        n = 0;
        while (!lock_loss_a && n < 20) begin step(1'b0, 1'b0); n++; end
        chk("lock_loss_delay", n, 2);
        chk("lock_loss_sys_rst", int'(sys_rst_a), 1);
        chk("lock_loss_ready", int'(ready_a), 0);
        n = 0;
        while (pll_rst_a && n < 20) begin n++; step(1'b0, 1'b1); end
        chk("lock_loss_pll_rst_len", n, 4);
        wait_ready(n, 1'b1, 100);
        chk("relock_ready", int'(ready_a), 1);
        chk("relock_retry", int'(retry_a), 0);

        // Glitchy lock
        step(1'b1, 1'b0);
        repeat (6) step(1'b0, 1'b0);
        repeat (5) step(1'b0, 1'b1);
        repeat (3) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        wait_ready(n, 1'b1, 60);
        chk("glitch_latency", n, 10);
        chk("glitch_retry", int'(retry_a), 0);

        // Timeout retries into FAIL
        step(1'b1, 1'b0);
        for (int k = 1; k <= 72; k++) begin
            step(1'b0, 1'b0);
            if (k == 24) chk("timeout_retry1", int'(retry_a), 1);
            if (k == 48) chk("timeout_retry2", int'(retry_a), 2);
            if (k == 71) chk("timeout_not_failed", int'(lock_fail_a), 0);
        end
        chk("fail_flag", int'(lock_fail_a), 1);
        chk("fail_retry", int'(retry_a), 3);
        chk("fail_pll_rst", int'(pll_rst_a), 1);
        repeat (30) step(1'b0, 1'b1);
        chk("fail_sticky", int'(lock_fail_a), 1);
        chk("fail_ignores_lock", int'(ready_a), 0);
        chk("fail_pll_rst_held", int'(pll_rst_a), 1);

        // rst in FAIL
        step(1'b1, 1'b1);
        chk_reset_vals("rst_in_fail");

        // rst in STABLE, then full resequence
        for (int k = 1; k <= 7; k++) step(1'b0, 1'b1);
        chk("stable_pll_rst", int'(pll_rst_a), 0);
        chk("stable_sys_rst", int'(sys_rst_a), 1);
        step(1'b1, 1'b1);
        chk_reset_vals("rst_in_stable");
        wait_ready(n, 1'b1, 60);
        chk("resequence_latency", n, 13);

        // Randomized lock behaviour with occasional resets
        while (stepn < 7400) begin
            lvl = int'($urandom_range(0, 1));
            len = lvl != 0 ? int'($urandom_range(1, 60)) : int'($urandom_range(1, 40));
            if ($urandom_range(0, 9) == 0) step(1'b1, lvl[0]);
            repeat (len) step(1'b0, lvl[0]);
        end

        // RETRY_MAX=0 instance after 300+ timeouts
        chk("b_retry_saturated", int'(retry_b), 255);
        chk("b_never_fails", int'(lock_fail_b), 0);
        chk("b_pulses_continue", int'(b_rises >= 5), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
